// File: rtl/gf2_4_div_arb.sv
// gf2_4_div_arb
// Shared GF(2^4) divider (primitive polynomial x^4+x+1) for the RS(15,9)
// decoder. Up to NUM_REQ requesters are arbitrated round-robin onto a single
// inverse table and a single GF multiplier. Each accepted operation returns
// num * den^-1 three cycles after the handshake. The result is tagged one-hot
// to the requester that issued it.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  per-requester request valid
//   req_ready_o  per-requester accept (at most one bit set, only in IDLE)
//   req_num_i    packed dividends, requester k at [k*4 +: 4]
//   req_den_i    packed divisors, same packing
//   rsp_valid_o  one-hot single-cycle result strobe
//   rsp_data_o   quotient (held between strobes)
//   rsp_div0_o   divisor was zero (held between strobes)
//   busy_o       operation in flight
module gf2_4_div_arb #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_num_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_den_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_data_o,
  output logic                           rsp_div0_o,
  output logic                           busy_o
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  // Low-order terms of x^4+x+1, folded back in whenever x^4 appears.
  localparam logic [DATA_WIDTH-1:0] POLY_LOW = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INV  = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gnt_sel;
  logic                  gnt_found;
  logic [DATA_WIDTH-1:0] num_sel;
  logic [DATA_WIDTH-1:0] den_sel;
  logic                  handshake;

  logic [IDX_W-1:0]      gnt_p0;
  logic [DATA_WIDTH-1:0] num_p0;
  logic [DATA_WIDTH-1:0] den_p0;
  logic [DATA_WIDTH-1:0] inv_p1;

  // Multiplicative inverse in GF(2^4); zero maps to zero so that a zero
  // divisor yields a zero quotient.
  function automatic logic [DATA_WIDTH-1:0] gf_inv(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    case (d)
      4'd1:    r = 4'd1;
      4'd2:    r = 4'd9;
      4'd3:    r = 4'd14;
      4'd4:    r = 4'd13;
      4'd5:    r = 4'd11;
      4'd6:    r = 4'd7;
      4'd7:    r = 4'd6;
      4'd8:    r = 4'd15;
      4'd9:    r = 4'd2;
      4'd10:   r = 4'd12;
      4'd11:   r = 4'd5;
      4'd12:   r = 4'd10;
      4'd13:   r = 4'd4;
      4'd14:   r = 4'd3;
      4'd15:   r = 4'd8;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // Shift-and-add polynomial multiply, reducing each shifted copy of a
  // modulo x^4+x+1 as it goes so no intermediate exceeds DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] gf_mul(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[DATA_WIDTH-2:0], 1'b0} ^ (sh[DATA_WIDTH-1] ? POLY_LOW : '0);
    end
    return acc;
  endfunction

  // Round-robin pick: the lowest valid index at or above rr_ptr wins;
  // otherwise the lowest valid index below it. The second loop runs last
  // so it overrides the wrap-around candidates.
  always_comb begin
    gnt_sel   = '0;
    gnt_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k] && (IDX_W'(k) < rr_ptr)) begin
        gnt_sel   = IDX_W'(k);
        gnt_found = 1'b1;
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k] && (IDX_W'(k) >= rr_ptr)) begin
        gnt_sel   = IDX_W'(k);
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    num_sel = '0;
    den_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_sel == IDX_W'(k)) begin
        num_sel = req_num_i[k*DATA_WIDTH +: DATA_WIDTH];
        den_sel = req_den_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign handshake = (state == S_IDLE) && gnt_found;
  assign busy_o    = (state != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Ready is forced low while reset is held so nothing appears accepted
  // during reset even though the state register reads IDLE.
  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    unique case (state)
      S_IDLE: begin
        if (gnt_found) begin
          state_nxt = S_INV;
          for (int k = 0; k < NUM_REQ; k++) begin
            req_ready_o[k] = ~rst_i & (gnt_sel == IDX_W'(k));
          end
        end
      end
      S_INV:   state_nxt = S_MUL;
      S_MUL:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      gnt_p0      <= '0;
      num_p0      <= '0;
      den_p0      <= '0;
      inv_p1      <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_div0_o  <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      // p0: operands captured at the handshake
      if (handshake) begin
        num_p0 <= num_sel;
        den_p0 <= den_sel;
        gnt_p0 <= gnt_sel;
        rr_ptr <= (gnt_sel == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_sel + 1'b1;
      end
      // p1: divisor inverse
      if (state == S_INV) begin
        inv_p1 <= gf_inv(den_p0);
      end
      // p2: product and tagged result strobe
      if (state == S_MUL) begin
        rsp_data_o  <= gf_mul(num_p0, inv_p1);
        rsp_div0_o  <= (den_p0 == '0);
        rsp_valid_o <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_p0;
      end
    end
  end

endmodule

// File: tb/tb_gf2_4_div_arb.sv
// Bench for gf2_4_div_arb with two requesters. Expected quotients come from
// log/antilog tables of GF(2^4) built from powers of alpha.
module tb_gf2_4_div_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_num;
  logic [7:0] req_den;
  logic [1:0] rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_div0;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int exp_t[15];
  int log_t[16];
  int w;
  int kk;
  int r0;
  int r1;
  int nr;
  int rsp_k[$];
  int rsp_c[$];

  always #5 clk = ~clk;

  gf2_4_div_arb #(.NUM_REQ(2), .DATA_WIDTH(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_num_i   (req_num),
    .req_den_i   (req_den),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_div0_o  (rsp_div0),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int ref_mul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 15];
  endfunction

  function automatic int ref_div(input int n, input int d);
    if (n == 0 || d == 0) return 0;
    return exp_t[(log_t[n] - log_t[d] + 15) % 15];
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge.
  task automatic do_op(input int k, input int n, input int d, output int waited);
    int cnt;
    cnt = 0;
    req_num[k*4 +: 4] = 4'(n);
    req_den[k*4 +: 4] = 4'(d);
    req_valid[k] = 1'b1;
    #1;
    while (req_ready[k] !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    waited = cnt;
    chk("grant", req_ready[k], 1);
    if (req_ready[k] !== 1'b1) begin
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    @(negedge clk);
    chk("inv_no_rsp", rsp_valid, 0);
    chk("inv_busy", busy, 1);
    chk("inv_no_ready", req_ready, 0);
    @(negedge clk);
    chk("mul_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 32'(1) << k);
    chk("rsp_data", rsp_data, ref_div(n, d));
    chk("rsp_div0", rsp_div0, (d == 0));
    chk("idle_busy", busy, 0);
    if (d != 0) chk("mulback", ref_mul(int'(rsp_data), d), n);
    @(negedge clk);
    chk("pulse_end", rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    e = 1;
    for (int i = 0; i < 15; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e << 1;
      if ((e & 16) != 0) e = e ^ 19;
    end
    log_t[0] = 0;

    rst = 1'b1;
    req_valid = 2'b00;
    req_num = '0;
    req_den = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_div0", rsp_div0, 0);
    chk("rst_busy", busy, 0);
    req_valid = 2'b11;
    #1 chk("rst_ready", req_ready, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // basic divide and latency
    do_op(0, 1, 2, w);
    chk("basic_wait", w, 0);
    chk("basic_q", rsp_data, 9);

    do_op(1, 5, 3, w);   chk("q_5_3", rsp_data, 3);
    do_op(1, 7, 7, w);   chk("q_7_7", rsp_data, 1);
    do_op(1, 0, 4, w);   chk("q_0_4", rsp_data, 0);
    do_op(1, 15, 1, w);  chk("q_15_1", rsp_data, 15);
    do_op(0, 8, 0, w);
    chk("div0_data", rsp_data, 0);
    chk("div0_flag", rsp_div0, 1);

    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 16; d++) begin
        do_op(int'($urandom_range(0, 1)), n, d, w);
      end
    end
    for (int i = 0; i < 30; i++) begin
      do_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), w);
    end

    // round robin with both requesters held valid from reset
    rst = 1'b1;
    req_num = {4'd9, 4'd3};
    req_den = {4'd6, 4'd5};
    req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("rr_onehot", ($countones(req_ready) <= 1), 1);
      if (rsp_valid != 2'b00) begin
        rsp_k.push_back(int'(rsp_valid));
        rsp_c.push_back(c);
        kk = (rsp_valid == 2'b10) ? 1 : 0;
        chk("rr_data", rsp_data, (kk == 1) ? ref_div(9, 6) : ref_div(3, 5));
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("rr_count", (rsp_k.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_k.size()) begin
        chk("rr_order", rsp_k[i], (i % 2 == 0) ? 1 : 2);
        if (i > 0) chk("rr_gap", rsp_c[i] - rsp_c[i-1], 3);
      end
    end
    repeat (4) @(negedge clk);
    chk("rr_drained", busy, 0);

    // withdrawn request while busy
    req_num[3:0] = 4'd6;
    req_den[3:0] = 4'd7;
    req_valid = 2'b01;
    #1 chk("wd_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 2'b10;
    req_num[7:4] = 4'd1;
    req_den[7:4] = 4'd1;
    #1 chk("wd_busy", busy, 1);
    chk("wd_no_ready", req_ready, 0);
    @(posedge clk);
    #1 req_valid = 2'b00;
    r0 = 0;
    r1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        r0++;
        chk("wd_data", rsp_data, ref_div(6, 7));
      end
      if (rsp_valid[1]) r1++;
    end
    chk("wd_r0", r0, 1);
    chk("wd_r1", r1, 0);
    repeat (3) @(negedge clk);
    chk("idle_busy2", busy, 0);
    req_valid = 2'b11;
    #1 chk("rr_hold_idle", req_ready, 2'b10);
    req_valid = 2'b00;
    #1 chk("ready_drop", req_ready, 0);
    @(negedge clk);

    // reset during INV
    req_num[3:0] = 4'd4;
    req_den[3:0] = 4'd3;
    req_valid = 2'b01;
    #1 chk("mid_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    chk("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_div0", rsp_div0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nr = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) nr++;
    end
    chk("mid_no_rsp", nr, 0);
    req_valid = 2'b11;
    #1 chk("mid_rr_reset", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);
    do_op(1, 6, 2, w);
    chk("clean_q", rsp_data, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf2_4_div_arb.md
Name: gf2_4_div_arb

Overview:
- Shared GF(2^4) division resource for the RS(15,9) decoder. Primitive polynomial x^4+x+1; alpha = 4'd2.
- Arbitrates NUM_REQ requesters (e.g. key-equation solver, Forney error-value stage) onto one combinational inverse LUT plus one GF multiplier.
- Each granted operation computes num * den^-1 and returns a registered result, tagged one-hot to the owning requester.
- Sequenced by a 3-state FSM with round-robin grant.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_WIDTH, 4, GF symbol width; fixed at 4 for GF(2^4).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
- req_num_i  input  NUM_REQ*DATA_WIDTH  dividends; requester k uses bits [k*4+3:k*4].
- req_den_i  input  NUM_REQ*DATA_WIDTH  divisors, same packing as req_num_i.
- rsp_valid_o  output  NUM_REQ  one-hot result strobe, 1 cycle.
- rsp_data_o  output  DATA_WIDTH  quotient num/den.
- rsp_div0_o  output  1  den was 0; valid with rsp_valid_o.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, rr_ptr=0, all operand/grant registers=0.
  - Reset outputs: req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_div0_o=0, busy_o=0.
- FSM states: IDLE -> INV -> MUL -> IDLE.
- IDLE:
  - Grant goes to the first k with req_valid_i[k]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready_o[k]=1 combinationally for the granted k only. All bits are 0 outside IDLE.
  - Handshake = req_valid_i[k] & req_ready_o[k] at a clock edge.
  - On handshake: latch num, den and grant index; set rr_ptr=(k+1) mod NUM_REQ; go to INV.
  - With no valid requests, stay in IDLE and leave rr_ptr unchanged.
- INV: register inv = GF inverse of the latched den (inv(0)=0 by definition); go to MUL.
  - Inverse table: 1->1, 2->9, 3->14, 4->13, 5->11, 6->7, 7->6, 8->15, 9->2, 10->12, 11->5, 12->10, 13->4, 14->3, 15->8.
- MUL: register the outputs, then go to IDLE.
  - rsp_data_o = num (x) inv, where (x) is polynomial multiply reduced mod x^4+x+1.
  - rsp_div0_o = (den==0).
  - rsp_valid_o = onehot(grant index).
- Latency and throughput:
  - For a handshake at edge E, rsp_valid_o is high exactly in the cycle after edge E+2.
  - req_ready_o can reassert in that same cycle, so throughput is 1 op per 3 cycles.
- rsp_data_o and rsp_div0_o hold their last values between strobes.
  - rsp_valid_o is a single-cycle pulse with no backpressure; requesters must capture it.
- den=0: rsp_data_o=0 and rsp_div0_o=1. num=0 with den!=0: rsp_data_o=0 and rsp_div0_o=0.
- Requesters hold valid and operands stable until ready. Dropping valid before the handshake withdraws the request with no side effect.
- Simultaneous requests: serviced strictly in round-robin order. No requester waits more than NUM_REQ operations.
- Reset asserted mid-operation: the in-flight operation is discarded, no rsp_valid_o is produced, and rr_ptr returns to 0.
- Arithmetic: pure XOR/AND logic, no carries; all widths are exactly DATA_WIDTH.

Test Plan:
- Basic divide, latency: after reset, req0 num=1, den=2 -> ready0 in the same cycle; rsp_valid_o=2'b01 with rsp_data_o=9 and div0=0 in the cycle after edge E+2, pulse 1 cycle.
- Arithmetic sweep: req1 5/3 -> 3; 7/7 -> 1; 0/4 -> 0; 15/1 -> 15. Exhaustive all 256 num/den pairs, with 0 expected when den=0; checker multiplies the result back by den and compares with num.
- Divide by zero: req0 num=8, den=0 -> rsp_data_o=0, rsp_div0_o=1, rsp_valid_o=2'b01.
- Round-robin: req0 and req1 both held valid from reset -> grant order 0,1,0,1. Responses spaced 3 cycles apart; req_ready_o never has 2 bits set.
- Withdraw and idle: req1 pulses valid for 1 cycle while busy_o=1 and is dropped -> no response for req1; rr_ptr unchanged while IDLE with no requests.
- Reset mid-op: assert rst_i in the INV state -> outputs go to 0 immediately, no rsp_valid_o. The next request from req1 gets a clean result (6/2 -> 3).
